// File: rtl/mux4_rr_sel.sv
// mux4_rr_sel: round-robin select controller feeding mux4_1, with a registered valid/ready output stage
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   req    in   [3:0] per-channel request (bit k -> channel k, mux input i(k+1))
//   ot_in  in   [W-1:0] mux output fed back from mux4_1
//   s      out  [1:0] mux select
//   gnt    out  [3:0] one-hot grant pulse in the capture cycle
//   vo     out  output data valid
//   ro     in   downstream ready
//   od     out  [W-1:0] captured channel data
//   ch     out  [1:0] channel index of od
//   cnt    out  [4*CW-1:0] saturating per-channel grant counters, only with MUX4_RR_CNT_EN defined
module mux4_rr_sel #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [W-1:0]  ot_in,
    output logic [1:0]    s,
    output logic [3:0]    gnt,
    output logic          vo,
    input  logic          ro,
    output logic [W-1:0]  od,
    output logic [1:0]    ch
`ifdef MUX4_RR_CNT_EN
    ,
    output logic [4*CW-1:0] cnt
`endif
);
    typedef enum logic [1:0] {IDLE, SEL, HOLD} state_t;
    state_t state, state_nx;
    logic [1:0] ptr, pick;
    // Scan downward so the set bit closest to ptr (in rotated order) wins.
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? SEL : IDLE;
            SEL:     state_nx = HOLD;
            HOLD:    state_nx = (vo && ro) ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s   <= '0;
            gnt <= '0;
            vo  <= 1'b0;
            od  <= '0;
            ch  <= '0;
            ptr <= '0;
        end else begin
            gnt <= '0;
            if (state == IDLE && |req) s <= pick;
            // SEL gives the mux a full cycle to settle before capture.
            if (state == SEL) begin
                od  <= ot_in;
                ch  <= s;
                vo  <= 1'b1;
                gnt <= 4'b0001 << s;
            end
            if (state == HOLD && vo && ro) begin
                vo  <= 1'b0;
                ptr <= ch + 2'd1;
            end
        end
    end
`ifdef MUX4_RR_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (state == SEL && cnt[s*CW +: CW] != {CW{1'b1}})
            cnt[s*CW +: CW] <= cnt[s*CW +: CW] + CW'(1);
`endif
endmodule
